// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: cache-line data memory with a fixed, programmable access
// latency. Accepts one 256-bit line read or write from the data cache
// controller, completes it LATENCY cycles later and answers with a one-cycle
// ack_o pulse.
//
// Optional build macro: DMEM_STATS_EN adds saturating completed-read and
// completed-write counters (rd_cnt_o, wr_cnt_o).
//
// Ports:
//   clk_i     in   1       clock, rising edge
//   rst_i     in   1       reset, asynchronous, active-low
//   addr_i    in   32      byte address of the line, bits [4:0] ignored
//   data_i    in   LINE_W  write data
//   enable_i  in   1       request valid, held until ack_o
//   write_i   in   1       1 = line write, 0 = line read
//   ack_o     out  1       one-cycle completion pulse
//   data_o    out  LINE_W  read data, valid from the ack_o cycle onward
//   busy_o    out  1       request in flight (BUSY or ACK)
//   rd_cnt_o  out  32      completed reads   (DMEM_STATS_EN only)
//   wr_cnt_o  out  32      completed writes  (DMEM_STATS_EN only)
module dmem_line_ctrl #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic                wr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic                accept;
    logic                finish;

    logic [LINE_W-1:0]   mem [DEPTH];

    // Address bits outside the line index are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAT_LAST) begin
                    finish  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request latches and outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= finish;
            if (accept) begin
                idx_q   <= addr_i[IDX_W+4:5];
                wr_q    <= write_i;
                wdata_q <= data_i;
            end
            if (finish && !wr_q)
                data_o <= mem[idx_q];
        end
    end

    // Array is not reset; a reset during BUSY returns the FSM to IDLE
    // asynchronously, so finish can never fire for an aborted request.
    always_ff @(posedge clk_i) begin
        if (finish && wr_q)
            mem[idx_q] <= wdata_q;
    end

    assign busy_o = (state_q != IDLE);

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (finish) begin
            if (wr_q) begin
                if (wr_cnt_o != '1)
                    wr_cnt_o <= wr_cnt_o + 32'd1;
            end else begin
                if (rd_cnt_o != '1)
                    rd_cnt_o <= rd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
